blk_mem_arbiter: RTL and testbench
==================================

# blk_mem_arbiter

Two-requester block-memory arbiter and sequencer that shares the single 256-bit main-memory block port between the instruction-cache refill path (read only) and the data-cache refill/writeback path (read or write). It sits between the cache controllers and the top-level iBlkRead/dBlkRead/dBlkWrite memory interface. It serialises transactions, round-robins ties, holds the downstream request until memory signals valid, and returns one-cycle completion pulses with registered data.

## Interface
- TIMEOUT_CYCLES, 64: busy cycles allowed before abort (used only with ARB_TIMEOUT_EN); legal range 2..65535.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  I-side block read request; held until i_done.
- i_addr  in  32  I-side block address; bits [4:0] ignored.
- i_done  out  1  one-cycle completion pulse to I-side.
- i_block  out  256  I-side read data, valid while i_done=1.
- d_req  in  1  D-side request; held until d_done.
- d_we  in  1  D-side direction: 1 write, 0 read; stable while d_req=1.
- d_addr  in  32  D-side block address; bits [4:0] ignored.
- d_wblock  in  256  D-side write data.
- d_done  out  1  one-cycle completion pulse to D-side.
- d_block  out  256  D-side read data, valid while d_done=1 and last op was a read.
- err  out  1  timeout abort flag, valid with i_done/d_done.
- mem_BlkRead  out  1  block read request to memory.
- mem_BlkWrite  out  1  block write request to memory.
- mem_addr  out  32  block address to memory, bits [4:0] forced 0.
- mem_block_write  out  256  write data to memory.
- mem_block_read  in  256  read data from memory.
- mem_block_read_valid  in  1  read completed this cycle.
- mem_block_write_valid  in  1  write completed this cycle.

## Operation
- States: IDLE, I_RD, D_RD, D_WR. Reset: IDLE, all outputs 0, last_grant=I.
- IDLE: eligible requesters = those with req=1 whose done is not asserted this cycle (masks stale req). None -> stay IDLE. One -> grant it. Both -> grant the one not equal to last_grant (first tie after reset goes to D).
- Grant: latch addr (bits [4:0] cleared) into mem_addr, d_wblock into mem_block_write (D write), set last_grant, go to I_RD / D_RD (d_we=0) / D_WR (d_we=1).
- I_RD, D_RD: mem_BlkRead=1 held. On mem_block_read_valid=1: register mem_block_read into i_block/d_block, pulse matching done next cycle, return to IDLE.
- D_WR: mem_BlkWrite=1 held. On mem_block_write_valid=1: pulse d_done next cycle, return to IDLE; d_block unchanged.
- Valid inputs in IDLE or of the wrong type for the current state are ignored.
- mem_BlkRead and mem_BlkWrite are never both 1; at most one transaction outstanding.
- Requests arriving mid-transaction wait; requester inputs are not re-sampled until the next grant.

## Timing
- All outputs registered.
- Request high in IDLE cycle N -> mem_BlkRead/mem_BlkWrite high in N+1.
- Valid in cycle M -> mem request low and done=1 in M+1; state is IDLE in M+1 and may grant the other requester in M+1, so its mem request rises in M+2.
- Minimum transaction: grant cycle + 1 mem cycle + done cycle = 3 cycles from req to done.
- Reset asserted mid-operation: immediate return to IDLE, outputs 0, transaction dropped without done; requesters reissue after reset.

## Configuration
- ARB_TIMEOUT_EN defined: a 16-bit counter clears on grant and increments each busy-state cycle. If it reaches TIMEOUT_CYCLES-1 with no matching valid, the arbiter drops the mem request, pulses the owner's done with err=1 and the data output zeroed, and returns to IDLE. Otherwise err=0 with every done.
- ARB_TIMEOUT_EN undefined: no counter; err tied 0; busy states wait indefinitely.

## Test plan
- I-only read, addr 0x0040_001F, valid on the 3rd busy cycle with data 0xA5..A5 -> mem_addr=0x0040_0000, mem_BlkRead high 3 cycles, i_done one cycle with i_block=0xA5..A5, err=0.
- Both req in the same cycle after reset (D read) -> D granted first. After d_done, I is granted in that same cycle and mem_BlkRead rises the next cycle.
- D write, d_wblock=0x1234..., valid after 5 cycles -> mem_BlkWrite high 5 cycles, mem_BlkRead stays 0, d_done pulses once, d_block unchanged.
- Continuous i_req and d_req over 6 transactions -> grants alternate D,I,D,I,D,I; no cycle has both mem requests high.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, I read with no valid -> i_done=1 and err=1 exactly 8 cycles after mem_BlkRead rose, i_block=0, back to IDLE.
- RESET low during D_WR -> mem_BlkWrite 0 immediately, no d_done. A subsequent read completes normally after RESET is released.

Source files
------------

// File: rtl/blk_mem_arbiter.sv
// Arbiter/sequencer sharing one 256-bit block memory port between I-cache reads and D-cache reads/writes.
// Define ARB_TIMEOUT_EN to abort transactions that stay busy for TIMEOUT_CYCLES without a matching valid.
module blk_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    output logic         i_done,
    output logic [255:0] i_block,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wblock,
    output logic         d_done,
    output logic [255:0] d_block,
    output logic         err,
    output logic         mem_BlkRead,
    output logic         mem_BlkWrite,
    output logic [31:0]  mem_addr,
    output logic [255:0] mem_block_write,
    input  logic [255:0] mem_block_read,
    input  logic         mem_block_read_valid,
    input  logic         mem_block_write_valid
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_I_RD  = 2'd1;
    localparam logic [1:0]  ST_D_RD  = 2'd2;
    localparam logic [1:0]  ST_D_WR  = 2'd3;
    localparam logic        GRANT_I  = 1'b0;
    localparam logic        GRANT_D  = 1'b1;
    localparam logic [31:0] BLK_MASK = 32'hFFFF_FFE0;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("blk_mem_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [1:0]   state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         mem_rd_q, mem_rd_d;
    logic         mem_wr_q, mem_wr_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [255:0] mem_wdata_q, mem_wdata_d;
    logic         i_done_q, i_done_d;
    logic         d_done_q, d_done_d;
    logic [255:0] i_block_q, i_block_d;
    logic [255:0] d_block_q, d_block_d;
    logic         err_q, err_d;
    logic         timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero while idle, so it is already clear on the first busy cycle after a grant.
    always_comb begin
        tmo_cnt_d = (state_q == ST_IDLE) ? 16'd0 : tmo_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end

    assign timeout_hit = (tmo_cnt_q == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // A requester whose done is high this cycle is still showing its old request.
    logic elig_i, elig_d, pick_d;
    assign elig_i = i_req & ~i_done_q;
    assign elig_d = d_req & ~d_done_q;
    assign pick_d = elig_d & (~elig_i | (last_grant_q == GRANT_I));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_block_d    = i_block_q;
        d_block_d    = d_block_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig_i || elig_d) begin
                    if (pick_d) begin
                        last_grant_d = GRANT_D;
                        mem_addr_d   = d_addr & BLK_MASK;
                        if (d_we) begin
                            state_d     = ST_D_WR;
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = d_wblock;
                        end else begin
                            state_d  = ST_D_RD;
                            mem_rd_d = 1'b1;
                        end
                    end else begin
                        last_grant_d = GRANT_I;
                        mem_addr_d   = i_addr & BLK_MASK;
                        state_d      = ST_I_RD;
                        mem_rd_d     = 1'b1;
                    end
                end
            end
            ST_I_RD: begin
                if (mem_block_read_valid) begin
                    i_block_d = mem_block_read;
                    i_done_d  = 1'b1;
                    mem_rd_d  = 1'b0;
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    i_block_d = '0;
                    i_done_d  = 1'b1;
                    err_d     = 1'b1;
                    mem_rd_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_D_RD: begin
                if (mem_block_read_valid) begin
                    d_block_d = mem_block_read;
                    d_done_d  = 1'b1;
                    mem_rd_d  = 1'b0;
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    d_block_d = '0;
                    d_done_d  = 1'b1;
                    err_d     = 1'b1;
                    mem_rd_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_D_WR: begin
                if (mem_block_write_valid) begin
                    d_done_d = 1'b1;
                    mem_wr_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (timeout_hit) begin
                    d_block_d = '0;
                    d_done_d  = 1'b1;
                    err_d     = 1'b1;
                    mem_wr_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the data registers are reset as well because every output must read 0 during reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_I;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_block_q    <= '0;
            d_block_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_block_q    <= i_block_d;
            d_block_q    <= d_block_d;
            err_q        <= err_d;
        end
    end

    assign mem_BlkRead     = mem_rd_q;
    assign mem_BlkWrite    = mem_wr_q;
    assign mem_addr        = mem_addr_q;
    assign mem_block_write = mem_wdata_q;
    assign i_done          = i_done_q;
    assign d_done          = d_done_q;
    assign i_block         = i_block_q;
    assign d_block         = d_block_q;
    assign err             = err_q;

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Scoreboard bench for blk_mem_arbiter: requester models, a latency-programmable memory responder
// and expected grant/completion queues. Define ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_blk_mem_arbiter;

    localparam int          TMO  = 8;
    localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};

    typedef struct {
        logic         is_d;
        logic         we;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           lat;     // busy cycle carrying valid; 0 = never respond
        logic         b2b;     // grant expected the cycle a previous done is shown
    } txn_t;

    typedef struct {
        logic [255:0] data;
        logic         err;
    } done_t;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [255:0] wdata;
    } dreq_t;

    logic         CLK, RESET;
    logic         i_req, i_done, d_req, d_we, d_done, err;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic [255:0] i_block, d_block, d_wblock, mem_block_write, mem_block_read;
    logic         mem_BlkRead, mem_BlkWrite, mem_block_read_valid, mem_block_write_valid;

    blk_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_block(i_block),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wblock(d_wblock),
        .d_done(d_done), .d_block(d_block), .err(err),
        .mem_BlkRead(mem_BlkRead), .mem_BlkWrite(mem_BlkWrite), .mem_addr(mem_addr),
        .mem_block_write(mem_block_write), .mem_block_read(mem_block_read),
        .mem_block_read_valid(mem_block_read_valid), .mem_block_write_valid(mem_block_write_valid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    txn_t         exp_grant_q[$];
    done_t        exp_i_q[$];
    done_t        exp_d_q[$];
    logic [31:0]  i_pend[$];
    dreq_t        d_pend[$];
    logic [255:0] model_d_block;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic post_i(input logic [31:0] addr, input int lat, input logic [255:0] rdata, input logic b2b);
        txn_t t;
        t = '{is_d: 1'b0, we: 1'b0, addr: addr & 32'hFFFF_FFE0, wdata: '0, rdata: rdata, lat: lat, b2b: b2b};
        exp_grant_q.push_back(t);
        if (lat == 0) exp_i_q.push_back('{data: '0, err: 1'b1});
        else          exp_i_q.push_back('{data: rdata, err: 1'b0});
        i_pend.push_back(addr);
    endtask

    task automatic post_d(input logic [31:0] addr, input logic we, input logic [255:0] wdata,
                          input logic [255:0] rdata, input int lat, input logic b2b);
        txn_t t;
        t = '{is_d: 1'b1, we: we, addr: addr & 32'hFFFF_FFE0, wdata: wdata, rdata: rdata, lat: lat, b2b: b2b};
        exp_grant_q.push_back(t);
        if (lat == 0) begin
            model_d_block = '0;
            exp_d_q.push_back('{data: '0, err: 1'b1});
        end else begin
            if (!we) model_d_block = rdata;
            exp_d_q.push_back('{data: model_d_block, err: 1'b0});
        end
        d_pend.push_back('{addr: addr, we: we, wdata: wdata});
    endtask

    // Requesters: hold the head request until its done, then present the next one.
    always @(posedge CLK) begin
        #1;
        if (!RESET) begin
            i_pend.delete();
            d_pend.delete();
            i_req = 1'b0;
            d_req = 1'b0;
        end else begin
            if (i_req && i_done) i_pend.delete(0);
            if (d_req && d_done) d_pend.delete(0);
            i_req = (i_pend.size() != 0);
            if (i_req) i_addr = i_pend[0];
            d_req = (d_pend.size() != 0);
            if (d_req) begin
                d_addr   = d_pend[0].addr;
                d_we     = d_pend[0].we;
                d_wblock = d_pend[0].wdata;
            end
        end
    end

    // Monitor + memory responder, sampling on the falling edge.
    txn_t cur;
    int   busy_cnt, done_due, cyc, last_done_cyc;
    logic prev_req, mem_req, fin_now;
    done_t e;

    always @(negedge CLK) begin
        cyc++;
        if (!RESET) begin
            prev_req              = 1'b0;
            busy_cnt              = 0;
            done_due              = 0;
            mem_block_read_valid  = 1'b0;
            mem_block_write_valid = 1'b0;
            mem_block_read        = JUNK;
        end else begin
            mem_req = mem_BlkRead | mem_BlkWrite;
            check("req_onehot", mem_BlkRead & mem_BlkWrite, 1'b0);
            if (done_due != 0) begin
                check(done_due == 1 ? "i_done_timing" : "d_done_timing",
                      done_due == 1 ? i_done : d_done, 1'b1);
                check("req_drop", mem_req, 1'b0);
                done_due = 0;
            end
            if (i_done) begin
                last_done_cyc = cyc;
                if (exp_i_q.size() == 0) check("i_done_spurious", i_done, 1'b0);
                else begin
                    e = exp_i_q.pop_front();
                    check("i_block", i_block, e.data);
                    check("i_err", err, e.err);
                end
            end
            if (d_done) begin
                last_done_cyc = cyc;
                if (exp_d_q.size() == 0) check("d_done_spurious", d_done, 1'b0);
                else begin
                    e = exp_d_q.pop_front();
                    check("d_block", d_block, e.data);
                    check("d_err", err, e.err);
                end
            end
            if (mem_req && !prev_req) begin
                if (exp_grant_q.size() == 0) begin
                    check("grant_spurious", mem_req, 1'b0);
                    cur = '{is_d: 1'b0, we: mem_BlkWrite, addr: '0, wdata: '0, rdata: '0, lat: 1, b2b: 1'b0};
                end else begin
                    cur = exp_grant_q.pop_front();
                    check("grant_addr", mem_addr, cur.addr);
                    check("grant_dir", mem_BlkWrite, cur.we);
                    if (cur.we) check("grant_wdata", mem_block_write, cur.wdata);
                    if (cur.b2b) check("grant_gap", cyc - last_done_cyc, 1);
                end
                busy_cnt = 0;
            end
            if (mem_req) begin
                busy_cnt++;
                check("req_dir_hold", mem_BlkWrite, cur.we);
                fin_now = (cur.lat != 0) && (busy_cnt == cur.lat);
                // Non-final busy cycles carry a valid of the wrong type, which must be ignored.
                mem_block_read_valid  = cur.we ? !fin_now : fin_now;
                mem_block_write_valid = cur.we ? fin_now : !fin_now;
                mem_block_read        = (!cur.we && fin_now) ? cur.rdata : JUNK;
                if (fin_now) done_due = cur.is_d ? 2 : 1;
`ifdef ARB_TIMEOUT_EN
                if (cur.lat == 0 && busy_cnt == TMO) done_due = cur.is_d ? 2 : 1;
`endif
            end else begin
                // Idle: both valids asserted with junk data, which must be ignored.
                mem_block_read_valid  = 1'b1;
                mem_block_write_valid = 1'b1;
                mem_block_read        = JUNK;
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_grant_q.size() != 0 || exp_i_q.size() != 0 || exp_d_q.size() != 0 ||
                i_req || d_req) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_complete"}, n < 500, 1'b1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        model_d_block = '0;
    endtask

    initial begin
        logic [255:0] r0, r1;
        int n;
        cyc           = 0;
        last_done_cyc = -10;
        model_d_block = '0;
        RESET    = 1'b0;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wblock = '0;
        repeat (3) @(negedge CLK);
        check("rst_mem_rd", mem_BlkRead, 1'b0);
        check("rst_mem_wr", mem_BlkWrite, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_block_write, '0);
        check("rst_i_done", i_done, 1'b0);
        check("rst_d_done", d_done, 1'b0);
        check("rst_i_block", i_block, '0);
        check("rst_d_block", d_block, '0);
        check("rst_err", err, 1'b0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // I-only read, low address bits must be cleared, valid on the 3rd busy cycle.
        post_i(32'h0040_001F, 3, {32{8'hA5}}, 1'b0);
        wait_idle("i_only");

        // Simultaneous requests: D first, I granted in the cycle d_done is shown.
        r0 = rand256();
        post_d(32'h8000_0123, 1'b0, '0, r0, 2, 1'b0);
        post_i(32'h0000_2040, 1, rand256(), 1'b1);
        wait_idle("tie");

        // D write: five busy cycles, d_block keeps the last read data.
        post_d(32'h8001_0000, 1'b1, {8{32'h1234_5678}}, '0, 5, 1'b0);
        wait_idle("d_write");

        // Fresh reset, then six back-to-back transactions alternating D,I,D,I,D,I.
        pulse_reset();
        r1 = rand256();
        post_d(32'h9000_0040, 1'b0, '0, r1, 2, 1'b0);
        post_i(32'h0000_0100, 1, rand256(), 1'b1);
        post_d(32'h9000_0080, 1'b1, rand256(), '0, 3, 1'b1);
        post_i(32'h0000_0120, 4, rand256(), 1'b1);
        post_d(32'h9000_00C0, 1'b0, '0, rand256(), 1, 1'b1);
        post_i(32'h0000_0140, 2, rand256(), 1'b1);
        wait_idle("alternate");

`ifdef ARB_TIMEOUT_EN
        // No memory response: abort with err after TMO busy cycles.
        post_i(32'h0000_3000, 0, '0, 1'b0);
        wait_idle("timeout");
        post_i(32'h0000_3020, 2, rand256(), 1'b0);
        wait_idle("after_timeout");
`endif

        // Reset in the middle of a write drops it without d_done.
        post_d(32'h8000_0AA0, 1'b1, rand256(), '0, 40, 1'b0);
        n = 0;
        while (!mem_BlkWrite && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("wr_started", mem_BlkWrite, 1'b1);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midrst_mem_wr", mem_BlkWrite, 1'b0);
        check("midrst_mem_rd", mem_BlkRead, 1'b0);
        check("midrst_mem_addr", mem_addr, '0);
        check("midrst_d_done", d_done, 1'b0);
        exp_grant_q.delete();
        exp_i_q.delete();
        exp_d_q.delete();
        model_d_block = '0;
        repeat (3) begin
            @(negedge CLK);
            check("rst_hold_d_done", d_done, 1'b0);
            check("rst_hold_mem_wr", mem_BlkWrite, 1'b0);
        end
        RESET = 1'b1;
        @(negedge CLK);
        post_d(32'h8000_0200, 1'b0, '0, rand256(), 2, 1'b0);
        post_i(32'h0000_0400, 3, rand256(), 1'b1);
        wait_idle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
